vga_scanout: RTL and testbench
==============================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal front porch/sync/back porch in clocks.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical front porch/sync/back porch in lines.
REQ-005 Parameter PIX_BITS, default 4, framebuffer word width.
REQ-006 Parameter COLOR_MODE, default MODE_GRAY; MODE_GRAY replicates the 4-bit word to R, G and B; MODE_RGB444 requires PIX_BITS=12 and maps [11:8]->R, [7:4]->G, [3:0]->B.
REQ-007 Parameter SCALE_SHIFT, default 0, range 0..2; each framebuffer pixel covers 2^S x 2^S screen pixels.
REQ-008 Parameter READ_LATENCY, default 2, memory clocks from address to data; legal range 1..4.
REQ-009 Parameter DOUBLE_BUF, default 1; when 1, two framebuffers are stored back to back.
REQ-010 Derived: FB_W=H_ACTIVE>>S, FB_H=V_ACTIVE>>S, ADDR_BITS=clog2(FB_W*FB_H*(DOUBLE_BUF+1)).
REQ-011 vga_clk_in  input  1  pixel clock; all logic on its rising edge.
REQ-012 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-013 buf_sel_in  input  1  requested display buffer; ignored when DOUBLE_BUF=0.
REQ-014 read_addr_out  output  ADDR_BITS  framebuffer read address.
REQ-015 read_data_in  input  PIX_BITS  framebuffer read data.
REQ-016 vga_r/vga_g/vga_b  output  4 each  colour pins.
REQ-017 vga_hs/vga_vs  output  1 each  syncs, active-low.
REQ-018 frame_start_out  output  1  one-clock pulse when the buffer selection is latched.
REQ-019 buf_active_out  output  1  buffer currently being scanned.

Function
REQ-020 Counters: hcount 0..H_TOTAL-1 and vcount 0..V_TOTAL-1, where H_TOTAL=sum of H params and V_TOTAL=sum of V params; vcount increments when hcount wraps; vcount wraps to 0 after V_TOTAL-1.
REQ-021 Active region: hcount<H_ACTIVE and vcount<V_ACTIVE; blank=not active.
REQ-022 hsync is asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on vcount.
REQ-023 Address for counter state (h,v) at cycle t is registered onto read_addr_out at t+1: buf_active*FB_W*FB_H + (v>>S)*FB_W + (h>>S); during blank it holds the last active address.
REQ-024 Memory data arrives at t+1+READ_LATENCY; colour is registered at t+2+READ_LATENCY.
REQ-025 hsync, vsync and blank are delayed by exactly READ_LATENCY+2 clocks, so the sync pins stay aligned with the colour pins.
REQ-026 When the delayed blank is asserted, vga_r/g/b SHALL be 0 regardless of read_data_in.
REQ-027 buf_sel_in is sampled only on the cycle with hcount=H_TOTAL-1 and vcount=V_TOTAL-1; that value drives buf_active_out from the next cycle, and frame_start_out pulses on that next cycle.
REQ-028 A buf_sel_in toggle mid-frame does not change read_addr_out until the next frame boundary.
REQ-029 When DOUBLE_BUF=0, buf_active_out is 0 and frame_start_out still pulses once per frame.
REQ-030 Address arithmetic uses at least ADDR_BITS+1 bits internally, with no truncation at the last pixel of buffer 1.

Reset
REQ-031 While rst_n_in is low: hcount=0, vcount=0, delay pipeline cleared to blank, read_addr_out=0, colour outputs 0, vga_hs=vga_vs=1 (deasserted), frame_start_out=0, buf_active_out=0.
REQ-032 On release, the first active pixel (0,0) colour appears READ_LATENCY+2 clocks after the first clock edge; reset asserted mid-line immediately forces the REQ-031 values.

Structure
REQ-033 vga_pkg holds the 640x480 timing defaults, the color_mode_t enum (MODE_GRAY, MODE_RGB444) and the sync polarity constant.
REQ-034 The counters and sync/blank decode form the sub-module vga_timing_gen, parameterised on the eight timing parameters; vga_scanout instantiates it once.

Verification
REQ-035 Default params, reset release: vga_hs low for 96 clocks per 800-clock line; vga_vs low for 2 lines per 525-line frame.
REQ-036 Model memory with READ_LATENCY=2 returning addr[3:0]: pixel (5,0) shows colour 5 on all channels, aligned with a high delayed-blank-free window; columns 640..799 show 0.
REQ-037 SCALE_SHIFT=1: screen pixels (0,0),(1,1) both read address 0; (2,0) reads 1; (0,2) reads 320.
REQ-038 buf_sel_in=1 asserted at line 100: addresses stay below 307200 until the frame wraps; then frame_start_out pulses once and (0,0) reads 307200.
REQ-039 COLOR_MODE=MODE_RGB444, data 12'hA5C: vga_r=A, vga_g=5, vga_b=C.
REQ-040 rst_n_in low at hcount=300 for 3 clocks: outputs take REQ-031 values asynchronously; scan restarts at (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480@60 timing defaults, colour-mode enum,
// sync polarity and the framebuffer-word to RGB mapping.
package vga_pkg;

  typedef enum logic [0:0] {
    MODE_GRAY   = 1'b0,
    MODE_RGB444 = 1'b1
  } color_mode_t;

  // 640x480 horizontal timing, in pixel clocks
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // 640x480 vertical timing, in lines
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Both syncs are active-low pins
  localparam logic SYNC_ACTIVE = 1'b0;

  // Word is always presented zero-extended to 12 bits; gray mode uses the low nibble only.
  function automatic logic [11:0] map_color(input color_mode_t mode, input logic [11:0] word);
    if (mode == MODE_RGB444) begin
      return word;
    end
    return {word[3:0], word[3:0], word[3:0]};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus combinational active/sync decode of the current counter state.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int H_BITS  = $clog2(H_TOTAL),
  localparam int V_BITS  = $clog2(V_TOTAL)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [H_BITS-1:0] hcount,
  output logic [V_BITS-1:0] vcount,
  output logic              active,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_end
);

  localparam logic [H_BITS-1:0] H_LAST     = H_BITS'(H_TOTAL - 1);
  localparam logic [V_BITS-1:0] V_LAST     = V_BITS'(V_TOTAL - 1);
  localparam logic [H_BITS-1:0] H_SYNC_BEG = H_BITS'(H_ACTIVE + H_FP);
  localparam logic [H_BITS-1:0] H_SYNC_END = H_BITS'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_BITS-1:0] V_SYNC_BEG = V_BITS'(V_ACTIVE + V_FP);
  localparam logic [V_BITS-1:0] V_SYNC_END = V_BITS'(V_ACTIVE + V_FP + V_SYNC);

  // Pixel counter wraps every line; line counter steps on each pixel wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      if (vcount == V_LAST) begin
        vcount <= '0;
      end else begin
        vcount <= vcount + V_BITS'(1);
      end
    end else begin
      hcount <= hcount + H_BITS'(1);
    end
  end

  assign active    = (hcount < H_BITS'(H_ACTIVE)) && (vcount < V_BITS'(V_ACTIVE));
  assign hsync     = (hcount >= H_SYNC_BEG) && (hcount < H_SYNC_END);
  assign vsync     = (vcount >= V_SYNC_BEG) && (vcount < V_SYNC_END);
  assign frame_end = (hcount == H_LAST) && (vcount == V_LAST);

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer scanout: raster timing, read-address generation, buffer
// selection at frame boundaries, and a sync/blank delay line matched to
// the memory read latency so syncs and colour leave on the same clock.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE     = DEF_H_ACTIVE,
  parameter int          H_FP         = DEF_H_FP,
  parameter int          H_SYNC       = DEF_H_SYNC,
  parameter int          H_BP         = DEF_H_BP,
  parameter int          V_ACTIVE     = DEF_V_ACTIVE,
  parameter int          V_FP         = DEF_V_FP,
  parameter int          V_SYNC       = DEF_V_SYNC,
  parameter int          V_BP         = DEF_V_BP,
  parameter int          PIX_BITS     = 4,
  parameter color_mode_t COLOR_MODE   = MODE_GRAY,
  parameter int          SCALE_SHIFT  = 0,
  parameter int          READ_LATENCY = 2,
  parameter int          DOUBLE_BUF   = 1,
  localparam int         FB_W         = H_ACTIVE >> SCALE_SHIFT,
  localparam int         FB_H         = V_ACTIVE >> SCALE_SHIFT,
  localparam int         FB_SIZE      = FB_W * FB_H,
  localparam int         ADDR_BITS    = $clog2(FB_SIZE * (DOUBLE_BUF + 1))
) (
  input  logic                 vga_clk_in,
  input  logic                 rst_n_in,
  input  logic                 buf_sel_in,
  output logic [ADDR_BITS-1:0] read_addr_out,
  input  logic [PIX_BITS-1:0]  read_data_in,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 frame_start_out,
  output logic                 buf_active_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_BITS  = $clog2(H_TOTAL);
  localparam int V_BITS  = $clog2(V_TOTAL);
  // One spare bit so buffer-1 offset plus last pixel never wraps before truncation
  localparam int ADDR_W  = ADDR_BITS + 1;
  // Address register, READ_LATENCY memory clocks, colour register
  localparam int PIPE    = READ_LATENCY + 2;

  logic [H_BITS-1:0] hcount;
  logic [V_BITS-1:0] vcount;
  logic              active;
  logic              hsync;
  logic              vsync;
  logic              frame_end;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (vga_clk_in),
    .rst_n     (rst_n_in),
    .hcount    (hcount),
    .vcount    (vcount),
    .active    (active),
    .hsync     (hsync),
    .vsync     (vsync),
    .frame_end (frame_end)
  );

  logic [ADDR_W-1:0] base_term;
  logic [ADDR_W-1:0] row_term;
  logic [ADDR_W-1:0] col_term;
  logic [ADDR_W-1:0] addr_full;

  // Linear framebuffer address of the current (scaled) raster position
  always_comb begin
    base_term = buf_active_out ? ADDR_W'(FB_SIZE) : '0;
    row_term  = ADDR_W'(vcount >> SCALE_SHIFT) * ADDR_W'(FB_W);
    col_term  = ADDR_W'(hcount >> SCALE_SHIFT);
    addr_full = base_term + row_term + col_term;
  end

  // Register the address while visible; hold the last visible address through blanking
  always_ff @(posedge vga_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      read_addr_out <= '0;
    end else if (active) begin
      read_addr_out <= addr_full[ADDR_BITS-1:0];
    end
  end

  // Latch the requested buffer only on the last clock of a frame so a frame never tears
  always_ff @(posedge vga_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      buf_active_out  <= 1'b0;
      frame_start_out <= 1'b0;
    end else begin
      frame_start_out <= frame_end;
      if (frame_end) begin
        buf_active_out <= (DOUBLE_BUF != 0) && buf_sel_in;
      end
    end
  end

  // Delay line for blank and sync pin levels; stage i holds the state from i+1 clocks ago
  genvar gi;
  for (gi = 0; gi < PIPE; gi++) begin : g_stage
    logic blank_d, hs_d, vs_d;
    logic blank_q, hs_q, vs_q;

    if (gi == 0) begin : g_src
      assign blank_d = ~active;
      assign hs_d    = hsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      assign vs_d    = vsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end else begin : g_src
      assign blank_d = g_stage[gi-1].blank_q;
      assign hs_d    = g_stage[gi-1].hs_q;
      assign vs_d    = g_stage[gi-1].vs_q;
    end

    // One delay stage; reset state is "blanked, syncs idle"
    always_ff @(posedge vga_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        blank_q <= 1'b1;
        hs_q    <= ~SYNC_ACTIVE;
        vs_q    <= ~SYNC_ACTIVE;
      end else begin
        blank_q <= blank_d;
        hs_q    <= hs_d;
        vs_q    <= vs_d;
      end
    end
  end

  assign vga_hs = g_stage[PIPE-1].hs_q;
  assign vga_vs = g_stage[PIPE-1].vs_q;

  logic [11:0] pix_word;
  logic [11:0] rgb_next;

  assign pix_word = 12'(read_data_in);
  assign rgb_next = map_color(COLOR_MODE, pix_word);

  // Colour register: memory data arrives together with delay stage READ_LATENCY,
  // so that stage's blank decides whether the pixel is forced dark
  always_ff @(posedge vga_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else if (g_stage[READ_LATENCY].blank_q) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else begin
      vga_r <= rgb_next[11:8];
      vga_g <= rgb_next[7:4];
      vga_b <= rgb_next[3:0];
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken 16x8 raster (24x13 totals).
// DUT A: gray, 1:1, double buffer, latency 2 -- full scoreboard plus directed points.
// DUT B: RGB444, 2x scale, single buffer, latency 1 -- directed points.
module tb_vga_scanout;
  import vga_pkg::*;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int RL_A = 2;
  localparam int BUF_SZ = HA * VA;

  typedef struct packed {
    logic [7:0] addr;
    logic       fs;
    logic       bufa;
  } a_item_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
  } v_item_t;

  logic clk, rst_n, buf_sel;

  logic [7:0]  addr_a;
  logic [3:0]  data_a;
  logic [3:0]  r_a, g_a, b_a;
  logic        hs_a, vs_a, fs_a, buf_a;
  logic [7:0]  mem_a1, mem_a2;

  logic [4:0]  addr_b;
  logic [11:0] data_b;
  logic [3:0]  r_b, g_b, b_b;
  logic        hs_b, vs_b, fs_b, buf_b;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_low = 0, vs_low = 0, fs_cnt = 0;

  a_item_t a_q[$];
  v_item_t v_q[$];
  int m_h = 0, m_v = 0, m_last = 0;
  logic m_buf = 1'b0;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIX_BITS(4), .COLOR_MODE(MODE_GRAY), .SCALE_SHIFT(0),
    .READ_LATENCY(RL_A), .DOUBLE_BUF(1)
  ) dut_a (
    .vga_clk_in(clk), .rst_n_in(rst_n), .buf_sel_in(buf_sel),
    .read_addr_out(addr_a), .read_data_in(data_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hs(hs_a), .vga_vs(vs_a),
    .frame_start_out(fs_a), .buf_active_out(buf_a)
  );

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIX_BITS(12), .COLOR_MODE(MODE_RGB444), .SCALE_SHIFT(1),
    .READ_LATENCY(1), .DOUBLE_BUF(0)
  ) dut_b (
    .vga_clk_in(clk), .rst_n_in(rst_n), .buf_sel_in(buf_sel),
    .read_addr_out(addr_b), .read_data_in(data_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b), .vga_vs(vs_b),
    .frame_start_out(fs_b), .buf_active_out(buf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory A: two-clock read returning addr[3:0]
  always @(posedge clk) begin
    mem_a1 <= addr_a;
    mem_a2 <= mem_a1;
  end
  assign data_a = mem_a2[3:0];

  // Memory B: one-clock read returning {A, 5, C ^ addr[3:0]}
  always @(posedge clk) begin
    data_b <= {4'hA, 4'h5, 4'hC ^ addr_b[3:0]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                       input bit verbose);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else if (verbose) begin
      $display("check %s: got %0h expected %0h ok", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr_a"}, 32'(addr_a), 32'd0, 1'b1);
    check({tag, "_rgb_a"}, 32'({r_a, g_a, b_a}), 32'd0, 1'b1);
    check({tag, "_hs_a"}, 32'(hs_a), 32'd1, 1'b1);
    check({tag, "_vs_a"}, 32'(vs_a), 32'd1, 1'b1);
    check({tag, "_fs_a"}, 32'(fs_a), 32'd0, 1'b1);
    check({tag, "_buf_a"}, 32'(buf_a), 32'd0, 1'b1);
    check({tag, "_addr_b"}, 32'(addr_b), 32'd0, 1'b1);
  endtask

  // Expected DUT A response for the raster state of the current cycle
  task automatic push_state();
    a_item_t ai;
    v_item_t vi;
    logic    act, fe;
    int      a;
    act = (m_h < HA) && (m_v < VA);
    if (act) begin
      a = (m_buf ? BUF_SZ : 0) + m_v * HA + m_h;
      m_last = a;
    end else begin
      a = m_last;
    end
    fe      = (m_h == HT - 1) && (m_v == VT - 1);
    ai.addr = 8'(a);
    ai.fs   = fe;
    ai.bufa = fe ? buf_sel : m_buf;
    a_q.push_back(ai);
    vi.r  = act ? 4'(a) : 4'd0;
    vi.g  = vi.r;
    vi.b  = vi.r;
    vi.hs = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
    vi.vs = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
    v_q.push_back(vi);
    m_buf = ai.bufa;
    if (m_h == HT - 1) begin
      m_h = 0;
      m_v = (m_v == VT - 1) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
  endtask

  task automatic flush_model();
    a_q.delete();
    v_q.delete();
    m_h = 0;
    m_v = 0;
    m_last = 0;
    m_buf = 1'b0;
  endtask

  // Stimulus-side scoreboard feeder: one expected entry per raster cycle
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) push_state();
    end
  end

  // Monitor: compare DUT A outputs against the head of each queue
  initial begin
    a_item_t ai;
    v_item_t vi;
    v_item_t idle;
    idle = '{r: 4'd0, g: 4'd0, b: 4'd0, hs: 1'b1, vs: 1'b1};
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (a_q.size() > 0) begin
          ai = a_q.pop_front();
          check("sb_addr_fs_buf", 32'({addr_a, fs_a, buf_a}), 32'(ai), 1'b0);
        end
        if (v_q.size() >= RL_A + 2) begin
          vi = v_q.pop_front();
          check("sb_rgb_sync", 32'({r_a, g_a, b_a, hs_a, vs_a}), 32'(vi), 1'b0);
        end else begin
          check("sb_pipe_fill_idle", 32'({r_a, g_a, b_a, hs_a, vs_a}), 32'(idle), 1'b0);
        end
      end
    end
  end

  task automatic run1_checks(input int k);
    if (k >= 313 && k <= 624) begin
      hs_low += (hs_a == 1'b0) ? 1 : 0;
      vs_low += (vs_a == 1'b0) ? 1 : 0;
      fs_cnt += (fs_a == 1'b1) ? 1 : 0;
    end
    case (k)
      2:   check("a_addr_pix1", 32'(addr_a), 32'd1, 1'b1);
      3: begin
        check("b_addr_pix2_0", 32'(addr_b), 32'd1, 1'b1);
        check("b_rgb444_A5C", 32'({r_b, g_b, b_b}), 32'hA5C, 1'b1);
      end
      5:   check("b_blue_pix2_0", 32'(b_b), 32'hD, 1'b1);
      9:   check("a_rgb_pix5", 32'({r_a, g_a, b_a}), 32'h555, 1'b1);
      26:  check("b_addr_pix1_1", 32'(addr_b), 32'd0, 1'b1);
      49:  check("b_addr_pix0_2", 32'(addr_b), 32'd8, 1'b1);
      311: check("a_fs_before_wrap", 32'(fs_a), 32'd0, 1'b1);
      312: begin
        check("a_fs_wrap", 32'(fs_a), 32'd1, 1'b1);
        check("a_buf_wrap", 32'(buf_a), 32'd1, 1'b1);
        check("a_addr_hold_blank", 32'(addr_a), 32'd127, 1'b1);
        check("b_fs_wrap", 32'(fs_b), 32'd1, 1'b1);
        check("b_buf_single", 32'(buf_b), 32'd0, 1'b1);
      end
      313: begin
        check("a_addr_buf1_origin", 32'(addr_a), 32'd128, 1'b1);
        check("a_fs_one_clock", 32'(fs_a), 32'd0, 1'b1);
      end
      624: begin
        check("a_hs_low_per_frame", 32'(hs_low), 32'(HS * VT), 1'b1);
        check("a_vs_low_per_frame", 32'(vs_low), 32'(VS * HT), 1'b1);
        check("a_fs_pulses_per_frame", 32'(fs_cnt), 32'd1, 1'b1);
      end
      default: ;
    endcase
  endtask

  task automatic run2_checks(input int k);
    case (k)
      2:   check("r2_addr_restart", 32'(addr_a), 32'd1, 1'b1);
      9:   check("r2_rgb_pix5", 32'({r_a, g_a, b_a}), 32'h555, 1'b1);
      313: check("r2_addr_buf1_origin", 32'(addr_a), 32'd128, 1'b1);
      600: check("r2_addr_no_midframe_switch", 32'(addr_a), 32'd255, 1'b1);
      624: begin
        check("r2_fs_wrap", 32'(fs_a), 32'd1, 1'b1);
        check("r2_buf_back_to_0", 32'(buf_a), 32'd0, 1'b1);
      end
      625: check("r2_addr_buf0_origin", 32'(addr_a), 32'd0, 1'b1);
      default: ;
    endcase
  endtask

  initial begin
    rst_n   = 1'b0;
    buf_sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("init");
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    for (int k = 1; k <= 706; k++) begin
      @(posedge clk);
      #2;
      if (k == 3 * HT) buf_sel = 1'b1;
      @(negedge clk);
      run1_checks(k);
    end

    // Cycle 706 sits at hcount=10 of a visible line in buffer 1
    #3;
    rst_n = 1'b0;
    flush_model();
    #1;
    check_reset_values("async");
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;

    for (int k = 1; k <= 650; k++) begin
      @(posedge clk);
      #2;
      if (k == 400) buf_sel = 1'b0;
      @(negedge clk);
      run2_checks(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
